fpnew_dotp_accum_seq: RTL and testbench

- Sequencer that computes a multi-beat reduction sum(a_i·b_i) + acc on the expanding dot-product unit (fpnew_dotp_wrapper).
- Issues one SDOTP per operand beat. Each beat's result is fed back as the next beat's addend (operand 2), so exactly one operation is in flight at a time.
- Sits between a command/operand stream source (e.g. a vector lane front-end) and the dot-product unit. Returns one final result plus the OR of all status flags.

---
 rtl/fpnew_dotp_accum_seq.sv | 191 +++++++++++++++++++
 tb/tb_fpnew_dotp_accum_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_dotp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_dotp_accum_seq (with fpnew_pkg type subset)
// Purpose  : Sequences a multi-beat reduction sum(a_i*b_i) + acc on the
//            expanding dot-product unit. One SDOTP per operand beat, each
//            beat's result fed back as the next beat's addend.
// Revision : 1.0 - initial release
// ============================================================================

package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD, SDOTP
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

module fpnew_dotp_accum_seq #(
  parameter int unsigned Width    = 32,
  parameter int unsigned LenWidth = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  // command stream
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [LenWidth-1:0]         len_i,
  input  logic [Width-1:0]            acc_init_i,
  input  fpnew_pkg::fp_format_e       src_fmt_i,
  input  fpnew_pkg::fp_format_e       dst_fmt_i,
  input  fpnew_pkg::roundmode_e       rnd_mode_i,
  // operand beat stream
  input  logic                        op_valid_i,
  output logic                        op_ready_o,
  input  logic [Width-1:0]            opa_i,
  input  logic [Width-1:0]            opb_i,
  // dot-product unit request side
  output logic [2:0][Width-1:0]       dotp_operands_o,
  output fpnew_pkg::operation_e       dotp_op_o,
  output logic                        dotp_op_mod_o,
  output fpnew_pkg::fp_format_e       dotp_src_fmt_o,
  output fpnew_pkg::fp_format_e       dotp_dst_fmt_o,
  output fpnew_pkg::roundmode_e       dotp_rnd_mode_o,
  output logic                        dotp_in_valid_o,
  input  logic                        dotp_in_ready_i,
  // dot-product unit response side
  input  logic [Width-1:0]            dotp_result_i,
  input  fpnew_pkg::status_t          dotp_status_i,
  input  logic                        dotp_out_valid_i,
  output logic                        dotp_out_ready_o,
  output logic                        dotp_flush_o,
  // final result
  output logic [Width-1:0]            result_o,
  output fpnew_pkg::status_t          status_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [Width-1:0]      acc_q;
  logic [LenWidth-1:0]   cnt_q;
  fpnew_pkg::status_t    status_q;
  fpnew_pkg::fp_format_e src_fmt_q, dst_fmt_q;
  fpnew_pkg::roundmode_e rnd_mode_q;

  logic cmd_fire;
  logic res_fire;

  assign cmd_fire = (state_q == IDLE) && cmd_valid_i;
  assign res_fire = (state_q == WAIT) && dotp_out_valid_i;

  // Next-state and handshake decode; flush overrides every event.
  always_comb begin
    state_d          = state_q;
    cmd_ready_o      = 1'b0;
    op_ready_o       = 1'b0;
    dotp_in_valid_o  = 1'b0;
    dotp_out_ready_o = 1'b0;
    out_valid_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = (len_i == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        dotp_in_valid_o = op_valid_i;
        op_ready_o      = dotp_in_ready_i;
        if (op_valid_i && dotp_in_ready_i) state_d = WAIT;
      end
      WAIT: begin
        dotp_out_ready_o = 1'b1;
        if (dotp_out_valid_i) state_d = (cnt_q == LenWidth'(1)) ? DONE : ISSUE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d         = IDLE;
      out_valid_o     = 1'b0;
      dotp_in_valid_o = 1'b0;
      op_ready_o      = 1'b0;
    end
  end

  // State register, accumulator, beat counter, sticky flags and latched command fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      status_q   <= '0;
      src_fmt_q  <= fpnew_pkg::FP32;
      dst_fmt_q  <= fpnew_pkg::FP32;
      rnd_mode_q <= fpnew_pkg::RNE;
    end else if (flush_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        acc_q      <= acc_init_i;
        cnt_q      <= len_i;
        status_q   <= '0;
        src_fmt_q  <= src_fmt_i;
        dst_fmt_q  <= dst_fmt_i;
        rnd_mode_q <= rnd_mode_i;
      end
      if (res_fire) begin
        acc_q    <= dotp_result_i;
        status_q <= status_q | dotp_status_i;
        cnt_q    <= cnt_q - LenWidth'(1);
      end
    end
  end

  // The running accumulator is always operand 2; multiplicands pass straight through.
  assign dotp_operands_o = {acc_q, opb_i, opa_i};
  assign dotp_op_o       = fpnew_pkg::SDOTP;
  assign dotp_op_mod_o   = 1'b0;
  assign dotp_src_fmt_o  = src_fmt_q;
  assign dotp_dst_fmt_o  = dst_fmt_q;
  assign dotp_rnd_mode_o = rnd_mode_q;
  assign dotp_flush_o    = flush_i;

  assign result_o = (state_q == DONE) ? acc_q : '0;
  assign status_o = (state_q == DONE) ? status_q : '0;
  assign busy_o   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpnew_dotp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_dotp_accum_seq
// Purpose  : Self-checking bench for fpnew_dotp_accum_seq with a behavioural
//            dot-product unit model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================

module tb_fpnew_dotp_accum_seq;
  import fpnew_pkg::*;

  localparam int W  = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               flush;
  logic               cmd_valid, cmd_ready;
  logic [LW-1:0]      len;
  logic [W-1:0]       acc_init;
  fp_format_e         src_fmt, dst_fmt;
  roundmode_e         rnd_mode;
  logic               op_valid, op_ready;
  logic [W-1:0]       opa, opb;
  logic [2:0][W-1:0]  dotp_operands;
  operation_e         dotp_op;
  logic               dotp_op_mod;
  fp_format_e         dotp_src_fmt, dotp_dst_fmt;
  roundmode_e         dotp_rnd_mode;
  logic               dotp_in_valid, dotp_in_ready;
  logic [W-1:0]       dotp_result;
  status_t            dotp_status;
  logic               dotp_out_valid, dotp_out_ready, dotp_flush;
  logic [W-1:0]       result;
  status_t            status;
  logic               out_valid, out_ready, busy;

  fpnew_dotp_accum_seq #(.Width(W), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .len_i(len),
    .acc_init_i(acc_init), .src_fmt_i(src_fmt), .dst_fmt_i(dst_fmt),
    .rnd_mode_i(rnd_mode),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .opa_i(opa), .opb_i(opb),
    .dotp_operands_o(dotp_operands), .dotp_op_o(dotp_op), .dotp_op_mod_o(dotp_op_mod),
    .dotp_src_fmt_o(dotp_src_fmt), .dotp_dst_fmt_o(dotp_dst_fmt),
    .dotp_rnd_mode_o(dotp_rnd_mode),
    .dotp_in_valid_o(dotp_in_valid), .dotp_in_ready_i(dotp_in_ready),
    .dotp_result_i(dotp_result), .dotp_status_i(dotp_status),
    .dotp_out_valid_i(dotp_out_valid), .dotp_out_ready_o(dotp_out_ready),
    .dotp_flush_o(dotp_flush),
    .result_o(result), .status_o(status), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy)
  );

  // Behavioural unit: FP16 pattern 1.0*1.0*2 + 2.0*2.0... yields +4.0 per beat
  // for the known accumulator chain; otherwise a simple integer mix of the
  // operands stands in for the arithmetic. Flags come from opa[4:0].
  function automatic logic [31:0] ufn(input logic [31:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    if (a == 32'h3C003C00 && b == 32'h40004000) begin
      case (c)
        32'h3F800000: return 32'h40A00000;
        32'h40A00000: return 32'h41100000;
        32'h41100000: return 32'h41500000;
        default:      return c + (a ^ (b << 1));
      endcase
    end
    return c + (a ^ (b << 1));
  endfunction

  int          unit_lat;
  logic        unit_stall;
  logic        u_busy, u_out_v;
  int          u_cd;
  logic [31:0] u_res;
  status_t     u_st;
  int unsigned issue_cnt, vcycles;
  logic [31:0] iss_op2 [0:1023];

  assign dotp_in_ready  = !u_busy && !unit_stall;
  assign dotp_out_valid = u_out_v;
  assign dotp_result    = u_res;
  assign dotp_status    = u_st;

  // One-deep unit model with programmable latency and input stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_busy <= 1'b0; u_out_v <= 1'b0; u_cd <= 0; u_res <= '0; u_st <= '0;
      issue_cnt <= 0; vcycles <= 0;
    end else if (dotp_flush) begin
      u_busy <= 1'b0; u_out_v <= 1'b0;
    end else begin
      if (dotp_in_valid) vcycles <= vcycles + 1;
      if (dotp_in_valid && dotp_in_ready) begin
        u_busy <= 1'b1;
        u_cd   <= unit_lat;
        u_res  <= ufn(dotp_operands[2], dotp_operands[0], dotp_operands[1]);
        u_st   <= status_t'(dotp_operands[0][4:0]);
        iss_op2[issue_cnt[9:0]] <= dotp_operands[2];
        issue_cnt <= issue_cnt + 1;
      end else if (u_busy && !u_out_v) begin
        if (u_cd == 0) u_out_v <= 1'b1;
        else           u_cd <= u_cd - 1;
      end
      if (u_out_v && dotp_out_ready) begin
        u_out_v <= 1'b0; u_busy <= 1'b0;
      end
    end
  end

  typedef struct packed { logic [31:0] res; logic [4:0] st; } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          len;
    logic [31:0] acc;
    logic [31:0] seed;
    int          lat;
    logic [31:0] exp_res;
    logic [4:0]  exp_st;
  } vec_t;
  vec_t vecs[6];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] beat_a(input logic [31:0] seed, input int k);
    return (seed * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B);
  endfunction
  function automatic logic [31:0] beat_b(input logic [31:0] seed, input int k);
    return (seed + 32'(k)) * 32'hC2B2AE35;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input int l, input logic [31:0] a, input fp_format_e sf,
                          input fp_format_e df, input roundmode_e rm);
    int n = 0;
    cmd_valid = 1'b1; len = LW'(l); acc_init = a;
    src_fmt = sf; dst_fmt = df; rnd_mode = rm;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("cmd_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    op_valid = 1'b1; opa = a; opb = b;
    @(negedge clk);
    while (op_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("beat_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // Waits for a final result and compares it against the scoreboard head.
  task automatic collect(input string name, output int waited);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    waited = n;
    if (n >= 2000) begin
      check({name, "_timeout"}, 32'(n), 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_res"}, result, e.res);
      check({name, "_st"}, {27'd0, status}, {27'd0, e.st});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base, v0;
    logic [31:0] c, a, b, ea;
    logic [4:0] s;

    // Table: inputs plus expected outputs computed from the unit model.
    vecs[0] = '{1,   32'h00000000, 32'h0000000B, 0, '0, '0};
    vecs[1] = '{2,   32'hDEADBEEF, 32'h00000016, 1, '0, '0};
    vecs[2] = '{5,   32'h01234567, 32'h00000021, 3, '0, '0};
    vecs[3] = '{8,   32'hFFFFFFFF, 32'h0000002C, 0, '0, '0};
    vecs[4] = '{3,   32'h80000000, 32'h00000042, 2, '0, '0};
    vecs[5] = '{255, 32'h3F800000, 32'h00000037, 0, '0, '0};
    for (int i = 0; i < 6; i++) begin
      c = vecs[i].acc; s = '0;
      for (int k = 0; k < vecs[i].len; k++) begin
        a = beat_a(vecs[i].seed, k); b = beat_b(vecs[i].seed, k);
        c = ufn(c, a, b); s = s | a[4:0];
      end
      vecs[i].exp_res = c; vecs[i].exp_st = s;
    end

    flush = 0; cmd_valid = 0; len = '0; acc_init = '0;
    src_fmt = FP32; dst_fmt = FP32; rnd_mode = RNE;
    op_valid = 0; opa = '0; opb = '0; out_ready = 1;
    unit_lat = 0; unit_stall = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dotp_in_valid", 32'(dotp_in_valid), 32'd0);
    check("rst_dotp_out_ready", 32'(dotp_out_ready), 32'd0);
    @(posedge clk); #1;

    // Basic FP16->FP32 reduction: 1.0 + 3 * 4.0
    exp_q.push_back('{32'h41500000, 5'd0});
    base = int'(issue_cnt);
    send_cmd(3, 32'h3F800000, FP16, FP32, RNE);
    for (int k = 0; k < 3; k++) send_beat(32'h3C003C00, 32'h40004000);
    collect("basic", w);
    check("basic_op2_0", iss_op2[base], 32'h3F800000);
    check("basic_op2_1", iss_op2[base + 1], 32'h40A00000);
    check("basic_op2_2", iss_op2[base + 2], 32'h41100000);

    // Zero-length command: result straight from acc_init, nothing issued
    v0 = int'(vcycles);
    exp_q.push_back('{32'h12345678, 5'd0});
    send_cmd(0, 32'h12345678, FP16, FP32, RNE);
    collect("len0", w);
    check("len0_latency", 32'(w), 32'd0);
    check("len0_no_issue", vcycles, 32'(v0));

    // Table-driven reductions with varied latency and lengths up to the maximum
    for (int i = 0; i < 6; i++) begin
      unit_lat = vecs[i].lat;
      exp_q.push_back('{vecs[i].exp_res, vecs[i].exp_st});
      send_cmd(vecs[i].len, vecs[i].acc, FP8, FP16, RDN);
      for (int k = 0; k < vecs[i].len; k++)
        send_beat(beat_a(vecs[i].seed, k), beat_b(vecs[i].seed, k));
      collect($sformatf("vec%0d", i), w);
    end
    unit_lat = 0;

    // Issue back-pressure then result back-pressure
    unit_stall = 1'b1;
    a = 32'h00003C00; b = 32'h00004400;
    ea = ufn(32'hA5A50000, a, b);
    exp_q.push_back('{ea, 5'd0});
    send_cmd(1, 32'hA5A50000, FP16, FP32, RTZ);
    src_fmt = FP64; dst_fmt = FP8; rnd_mode = RMM;
    op_valid = 1'b1; opa = a; opb = b;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_op_ready", 32'(op_ready), 32'd0);
      check("bp_in_valid", 32'(dotp_in_valid), 32'd1);
      check("bp_op2", dotp_operands[2], 32'hA5A50000);
      check("bp_opa", dotp_operands[0], a);
      check("bp_src_fmt", 32'(dotp_src_fmt), 32'(FP16));
      check("bp_rm", 32'(dotp_rnd_mode), 32'(RTZ));
    end
    @(posedge clk); #1;
    unit_stall = 1'b0;
    out_ready = 1'b0;
    send_beat(a, b);
    w = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    check("bp_done_reached", 32'(w < 200), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", result, ea);
      check("bp_hold_status", {27'd0, status}, 32'd0);
      check("bp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    collect("bp", w);

    // Status accumulation: NX then OF|NX
    c = ufn(ufn(32'h00000100, 32'h00000001, 32'h7), 32'h00000005, 32'h9);
    exp_q.push_back('{c, 5'b00101});
    send_cmd(2, 32'h00000100, FP16, FP32, RNE);
    send_beat(32'h00000001, 32'h7);
    send_beat(32'h00000005, 32'h9);
    collect("status", w);

    // Flush while waiting on beat 2 of 4, then a clean single-beat command
    unit_lat = 3;
    send_cmd(4, 32'h11110000, FP16, FP32, RNE);
    send_beat(32'h00000013, 32'h55);
    send_beat(32'h00000017, 32'h66);
    @(negedge clk);
    check("flush_in_wait", 32'(dotp_out_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_cmd_ready", 32'(cmd_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    unit_lat = 0;
    exp_q.push_back('{ufn(32'h00000040, 32'h00000002, 32'h3), 5'b00010});
    send_cmd(1, 32'h00000040, FP16, FP32, RNE);
    send_beat(32'h00000002, 32'h3);
    collect("post_flush", w);

    // Asynchronous reset in the middle of ISSUE
    unit_stall = 1'b1;
    send_cmd(2, 32'hCAFEF00D, FP16, FP32, RUP);
    op_valid = 1'b1; opa = 32'h1; opb = 32'h2;
    @(negedge clk);
    check("pre_rst_in_valid", 32'(dotp_in_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_in_valid", 32'(dotp_in_valid), 32'd0);
    check("arst_op2", dotp_operands[2], 32'd0);
    check("arst_src_fmt", 32'(dotp_src_fmt), 32'(FP32));
    @(posedge clk); #1;
    op_valid = 1'b0; unit_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    w = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) w++;
    end
    check("arst_no_spurious_valid", 32'(w), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
